// File: rtl/bus_arbiter_if.sv
// Handshake bundle shared by the fetch port, the data port and the downstream bus.
// The arbiter uses the slave modport; the surrounding masters and bus bridge use master.
interface bus_arbiter_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
);
    logic              bus_arb_if_valid_i;
    logic              bus_arb_if_ready_o;
    logic [ADDR_W-1:0] bus_arb_if_addr_i;
    logic [1:0]        bus_arb_if_size_i;
    logic [DATA_W-1:0] bus_arb_if_data_read_o;
    logic [1:0]        bus_arb_if_resp_o;

    logic              bus_arb_mem_valid_i;
    logic              bus_arb_mem_ready_o;
    logic              bus_arb_mem_req_i;
    logic [ADDR_W-1:0] bus_arb_mem_addr_i;
    logic [1:0]        bus_arb_mem_size_i;
    logic [DATA_W-1:0] bus_arb_mem_data_write_i;
    logic [DATA_W-1:0] bus_arb_mem_data_read_o;
    logic [1:0]        bus_arb_mem_resp_o;

    logic              bus_arb_bus_valid_o;
    logic              bus_arb_bus_ready_i;
    logic              bus_arb_bus_req_o;
    logic [ADDR_W-1:0] bus_arb_bus_addr_o;
    logic [1:0]        bus_arb_bus_size_o;
    logic [DATA_W-1:0] bus_arb_bus_data_write_o;
    logic [DATA_W-1:0] bus_arb_bus_data_read_i;
    logic [1:0]        bus_arb_bus_resp_i;

    logic [1:0]        bus_arb_owner_o;

    modport slave (
        input  bus_arb_if_valid_i, bus_arb_if_addr_i, bus_arb_if_size_i,
        output bus_arb_if_ready_o, bus_arb_if_data_read_o, bus_arb_if_resp_o,
        input  bus_arb_mem_valid_i, bus_arb_mem_req_i, bus_arb_mem_addr_i,
        input  bus_arb_mem_size_i, bus_arb_mem_data_write_i,
        output bus_arb_mem_ready_o, bus_arb_mem_data_read_o, bus_arb_mem_resp_o,
        output bus_arb_bus_valid_o, bus_arb_bus_req_o, bus_arb_bus_addr_o,
        output bus_arb_bus_size_o, bus_arb_bus_data_write_o,
        input  bus_arb_bus_ready_i, bus_arb_bus_data_read_i, bus_arb_bus_resp_i,
        output bus_arb_owner_o
    );

    modport master (
        output bus_arb_if_valid_i, bus_arb_if_addr_i, bus_arb_if_size_i,
        input  bus_arb_if_ready_o, bus_arb_if_data_read_o, bus_arb_if_resp_o,
        output bus_arb_mem_valid_i, bus_arb_mem_req_i, bus_arb_mem_addr_i,
        output bus_arb_mem_size_i, bus_arb_mem_data_write_i,
        input  bus_arb_mem_ready_o, bus_arb_mem_data_read_o, bus_arb_mem_resp_o,
        input  bus_arb_bus_valid_o, bus_arb_bus_req_o, bus_arb_bus_addr_o,
        input  bus_arb_bus_size_o, bus_arb_bus_data_write_o,
        output bus_arb_bus_ready_i, bus_arb_bus_data_read_i, bus_arb_bus_resp_i,
        input  bus_arb_owner_o
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master / one-slave bus arbiter: data port has priority, fetch is protected
// from starvation after STARVE_LIMIT consecutive contested data grants.
module bus_arbiter #(
    parameter int unsigned ADDR_W       = 64,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    bus_arbiter_if.slave  arb
);
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GNT_IF  = 2'b01,
        GNT_MEM = 2'b10
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_starve_cnt;

    logic              w_if_done;
    logic              w_mem_done;
    logic              w_starved;
    logic [ADDR_W-1:0] w_if_addr;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic [DATA_W-1:0] w_bus_rdata;

    assign w_if_addr   = arb.bus_arb_if_addr_i;
    assign w_mem_addr  = arb.bus_arb_mem_addr_i;
    assign w_mem_wdata = arb.bus_arb_mem_data_write_i;
    assign w_bus_rdata = arb.bus_arb_bus_data_read_i;

    // A bus ready only completes a transfer while the granted master still holds valid.
    assign w_if_done  = (r_state == GNT_IF)  && arb.bus_arb_if_valid_i  && arb.bus_arb_bus_ready_i;
    assign w_mem_done = (r_state == GNT_MEM) && arb.bus_arb_mem_valid_i && arb.bus_arb_bus_ready_i;
    assign w_starved  = (r_starve_cnt == CNT_W'(STARVE_LIMIT));

    assign arb.bus_arb_owner_o = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (arb.bus_arb_mem_valid_i && arb.bus_arb_if_valid_i) begin
                        if (w_starved) begin
                            r_state      <= GNT_IF;
                            r_starve_cnt <= '0;
                        end else begin
                            r_state      <= GNT_MEM;
                            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
                        end
                    end else if (arb.bus_arb_mem_valid_i) begin
                        r_state      <= GNT_MEM;
                        r_starve_cnt <= '0;
                    end else if (arb.bus_arb_if_valid_i) begin
                        r_state      <= GNT_IF;
                        r_starve_cnt <= '0;
                    end
                end
                // Leave on completion or when the owner withdraws (flush); counter untouched.
                GNT_IF: begin
                    if (!arb.bus_arb_if_valid_i || arb.bus_arb_bus_ready_i) begin
                        r_state <= IDLE;
                    end
                end
                GNT_MEM: begin
                    if (!arb.bus_arb_mem_valid_i || arb.bus_arb_bus_ready_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Bus mux and response steering; everything idles at zero.
    always_comb begin
        arb.bus_arb_bus_valid_o      = 1'b0;
        arb.bus_arb_bus_req_o        = 1'b0;
        arb.bus_arb_bus_addr_o       = '0;
        arb.bus_arb_bus_size_o       = 2'b00;
        arb.bus_arb_bus_data_write_o = '0;
        arb.bus_arb_if_ready_o       = 1'b0;
        arb.bus_arb_if_data_read_o   = '0;
        arb.bus_arb_if_resp_o        = 2'b00;
        arb.bus_arb_mem_ready_o      = 1'b0;
        arb.bus_arb_mem_data_read_o  = '0;
        arb.bus_arb_mem_resp_o       = 2'b00;
        case (r_state)
            GNT_IF: begin
                arb.bus_arb_bus_valid_o = arb.bus_arb_if_valid_i;
                arb.bus_arb_bus_addr_o  = w_if_addr;
                arb.bus_arb_bus_size_o  = arb.bus_arb_if_size_i;
                if (w_if_done) begin
                    arb.bus_arb_if_ready_o     = 1'b1;
                    arb.bus_arb_if_data_read_o = w_bus_rdata;
                    arb.bus_arb_if_resp_o      = arb.bus_arb_bus_resp_i;
                end
            end
            GNT_MEM: begin
                arb.bus_arb_bus_valid_o      = arb.bus_arb_mem_valid_i;
                arb.bus_arb_bus_req_o        = arb.bus_arb_mem_req_i;
                arb.bus_arb_bus_addr_o       = w_mem_addr;
                arb.bus_arb_bus_size_o       = arb.bus_arb_mem_size_i;
                arb.bus_arb_bus_data_write_o = w_mem_wdata;
                if (w_mem_done) begin
                    arb.bus_arb_mem_ready_o     = 1'b1;
                    arb.bus_arb_mem_data_read_o = w_bus_rdata;
                    arb.bus_arb_mem_resp_o      = arb.bus_arb_bus_resp_i;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: inputs change on the falling edge, outputs are
// checked 1 ns later, well clear of the rising edge.
module tb_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    bus_arbiter_if #(.ADDR_W(64), .DATA_W(64)) u_if ();

    bus_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .arb (u_if.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        u_if.bus_arb_if_valid_i       = 1'b0;
        u_if.bus_arb_if_addr_i        = '0;
        u_if.bus_arb_if_size_i        = 2'b00;
        u_if.bus_arb_mem_valid_i      = 1'b0;
        u_if.bus_arb_mem_req_i        = 1'b0;
        u_if.bus_arb_mem_addr_i       = '0;
        u_if.bus_arb_mem_size_i       = 2'b00;
        u_if.bus_arb_mem_data_write_i = '0;
        u_if.bus_arb_bus_ready_i      = 1'b0;
        u_if.bus_arb_bus_data_read_i  = '0;
        u_if.bus_arb_bus_resp_i       = 2'b00;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick(); tick();
        #1;
        n_cmp++; if (u_if.bus_arb_owner_o !== 2'b00) begin n_err++; $display("FAIL reset_owner: got %0h want 0", u_if.bus_arb_owner_o); end
        n_cmp++; if (u_if.bus_arb_bus_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_bus_valid: got %0b want 0", u_if.bus_arb_bus_valid_o); end
        n_cmp++; if ({u_if.bus_arb_if_ready_o, u_if.bus_arb_mem_ready_o} !== 2'b00) begin n_err++; $display("FAIL reset_readys: got %0b%0b want 00", u_if.bus_arb_if_ready_o, u_if.bus_arb_mem_ready_o); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_fetch_read();
        tick();
        u_if.bus_arb_if_valid_i = 1'b1;
        u_if.bus_arb_if_addr_i  = 64'h0000_0000_8000_0000;
        u_if.bus_arb_if_size_i  = 2'b10;
        #1;
        n_cmp++; if (u_if.bus_arb_bus_valid_o !== 1'b0) begin n_err++; $display("FAIL fetch_arb_cycle_valid: got %0b want 0", u_if.bus_arb_bus_valid_o); end
        tick(); #1;
        n_cmp++; if (u_if.bus_arb_owner_o !== 2'b01) begin n_err++; $display("FAIL fetch_owner: got %0h want 1", u_if.bus_arb_owner_o); end
        n_cmp++; if (u_if.bus_arb_bus_valid_o !== 1'b1) begin n_err++; $display("FAIL fetch_bus_valid: got %0b want 1", u_if.bus_arb_bus_valid_o); end
        n_cmp++; if (u_if.bus_arb_bus_addr_o !== 64'h8000_0000) begin n_err++; $display("FAIL fetch_bus_addr: got %h want 80000000", u_if.bus_arb_bus_addr_o); end
        n_cmp++; if (u_if.bus_arb_bus_req_o !== 1'b0) begin n_err++; $display("FAIL fetch_bus_req: got %0b want 0", u_if.bus_arb_bus_req_o); end
        n_cmp++; if (u_if.bus_arb_if_ready_o !== 1'b0) begin n_err++; $display("FAIL fetch_early_ready: got %0b want 0", u_if.bus_arb_if_ready_o); end
        tick(); #1;
        n_cmp++; if (u_if.bus_arb_owner_o !== 2'b01) begin n_err++; $display("FAIL fetch_wait_owner: got %0h want 1", u_if.bus_arb_owner_o); end
        tick();
        u_if.bus_arb_bus_ready_i     = 1'b1;
        u_if.bus_arb_bus_data_read_i = 64'h1122_3344_5566_7788;
        #1;
        n_cmp++; if (u_if.bus_arb_if_ready_o !== 1'b1) begin n_err++; $display("FAIL fetch_ready: got %0b want 1", u_if.bus_arb_if_ready_o); end
        n_cmp++; if (u_if.bus_arb_if_data_read_o !== 64'h1122_3344_5566_7788) begin n_err++; $display("FAIL fetch_rdata: got %h want 1122334455667788", u_if.bus_arb_if_data_read_o); end
        n_cmp++; if (u_if.bus_arb_mem_ready_o !== 1'b0 || u_if.bus_arb_mem_data_read_o !== 64'h0) begin n_err++; $display("FAIL fetch_mem_side_quiet: got ready %0b data %h want 0", u_if.bus_arb_mem_ready_o, u_if.bus_arb_mem_data_read_o); end
        tick();
        clear_inputs();
        #1;
        n_cmp++; if (u_if.bus_arb_owner_o !== 2'b00) begin n_err++; $display("FAIL fetch_owner_idle: got %0h want 0", u_if.bus_arb_owner_o); end
        n_cmp++; if (u_if.bus_arb_if_ready_o !== 1'b0) begin n_err++; $display("FAIL fetch_ready_pulse: got %0b want 0", u_if.bus_arb_if_ready_o); end
    endtask

    task automatic test_both_valid();
        tick();
        u_if.bus_arb_if_valid_i       = 1'b1;
        u_if.bus_arb_if_addr_i        = 64'h8000_0004;
        u_if.bus_arb_if_size_i        = 2'b10;
        u_if.bus_arb_mem_valid_i      = 1'b1;
        u_if.bus_arb_mem_req_i        = 1'b1;
        u_if.bus_arb_mem_addr_i       = 64'h8000_1000;
        u_if.bus_arb_mem_size_i       = 2'b11;
        u_if.bus_arb_mem_data_write_i = 64'hdead_beef;
        tick(); #1;
        n_cmp++; if (u_if.bus_arb_owner_o !== 2'b10) begin n_err++; $display("FAIL both_owner_data: got %0h want 2", u_if.bus_arb_owner_o); end
        n_cmp++; if (u_if.bus_arb_bus_req_o !== 1'b1) begin n_err++; $display("FAIL both_bus_req: got %0b want 1", u_if.bus_arb_bus_req_o); end
        n_cmp++; if (u_if.bus_arb_bus_data_write_o !== 64'hdead_beef) begin n_err++; $display("FAIL both_wdata: got %h want deadbeef", u_if.bus_arb_bus_data_write_o); end
        n_cmp++; if (u_if.bus_arb_bus_addr_o !== 64'h8000_1000 || u_if.bus_arb_bus_size_o !== 2'b11) begin n_err++; $display("FAIL both_addr_size: got %h/%0h want 80001000/3", u_if.bus_arb_bus_addr_o, u_if.bus_arb_bus_size_o); end
        u_if.bus_arb_bus_ready_i = 1'b1;
        u_if.bus_arb_bus_resp_i  = 2'b01;
        #1;
        n_cmp++; if (u_if.bus_arb_mem_ready_o !== 1'b1 || u_if.bus_arb_if_ready_o !== 1'b0) begin n_err++; $display("FAIL both_mem_done: got mem %0b if %0b want 1 0", u_if.bus_arb_mem_ready_o, u_if.bus_arb_if_ready_o); end
        n_cmp++; if (u_if.bus_arb_mem_resp_o !== 2'b01 || u_if.bus_arb_if_resp_o !== 2'b00) begin n_err++; $display("FAIL both_resp: got mem %0h if %0h want 1 0", u_if.bus_arb_mem_resp_o, u_if.bus_arb_if_resp_o); end
        tick();
        u_if.bus_arb_mem_valid_i = 1'b0;
        u_if.bus_arb_bus_ready_i = 1'b0;
        u_if.bus_arb_bus_resp_i  = 2'b00;
        #1;
        n_cmp++; if (u_if.bus_arb_owner_o !== 2'b00 || u_if.bus_arb_bus_valid_o !== 1'b0) begin n_err++; $display("FAIL both_bubble: got owner %0h valid %0b want 0 0", u_if.bus_arb_owner_o, u_if.bus_arb_bus_valid_o); end
        tick(); #1;
        n_cmp++; if (u_if.bus_arb_owner_o !== 2'b01) begin n_err++; $display("FAIL both_owner_fetch: got %0h want 1", u_if.bus_arb_owner_o); end
        n_cmp++; if (u_if.bus_arb_bus_addr_o !== 64'h8000_0004 || u_if.bus_arb_bus_req_o !== 1'b0 || u_if.bus_arb_bus_data_write_o !== 64'h0) begin n_err++; $display("FAIL both_fetch_bus: got addr %h req %0b wdata %h want 80000004 0 0", u_if.bus_arb_bus_addr_o, u_if.bus_arb_bus_req_o, u_if.bus_arb_bus_data_write_o); end
        u_if.bus_arb_bus_ready_i = 1'b1;
        #1;
        n_cmp++; if (u_if.bus_arb_if_ready_o !== 1'b1) begin n_err++; $display("FAIL both_fetch_done: got %0b want 1", u_if.bus_arb_if_ready_o); end
        tick();
        clear_inputs();
    endtask

    task automatic test_starvation();
        logic [1:0] exp_owner [19];
        for (int i = 0; i < 19; i++) exp_owner[i] = 2'b00;
        for (int i = 0; i < 19; i += 2) exp_owner[i] = 2'b10;
        exp_owner[8]  = 2'b01;
        exp_owner[18] = 2'b01;
        tick();
        u_if.bus_arb_if_valid_i  = 1'b1;
        u_if.bus_arb_if_addr_i   = 64'h8000_0040;
        u_if.bus_arb_mem_valid_i = 1'b1;
        u_if.bus_arb_mem_addr_i  = 64'h8000_2040;
        u_if.bus_arb_bus_ready_i = 1'b1;
        for (int i = 0; i < 19; i++) begin
            tick(); #1;
            n_cmp++; if (u_if.bus_arb_owner_o !== exp_owner[i]) begin n_err++; $display("FAIL starve_owner[%0d]: got %0h want %0h", i, u_if.bus_arb_owner_o, exp_owner[i]); end
            n_cmp++; if (u_if.bus_arb_mem_ready_o !== exp_owner[i][1] || u_if.bus_arb_if_ready_o !== exp_owner[i][0]) begin n_err++; $display("FAIL starve_ready[%0d]: got mem %0b if %0b want %0b %0b", i, u_if.bus_arb_mem_ready_o, u_if.bus_arb_if_ready_o, exp_owner[i][1], exp_owner[i][0]); end
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_abort();
        tick();
        u_if.bus_arb_mem_valid_i = 1'b1;
        u_if.bus_arb_mem_addr_i  = 64'h8000_2000;
        u_if.bus_arb_mem_size_i  = 2'b11;
        tick(); #1;
        n_cmp++; if (u_if.bus_arb_owner_o !== 2'b10 || u_if.bus_arb_bus_valid_o !== 1'b1) begin n_err++; $display("FAIL abort_grant: got owner %0h valid %0b want 2 1", u_if.bus_arb_owner_o, u_if.bus_arb_bus_valid_o); end
        tick();
        tick();
        u_if.bus_arb_mem_valid_i = 1'b0;
        u_if.bus_arb_bus_ready_i = 1'b1;
        #1;
        n_cmp++; if (u_if.bus_arb_mem_ready_o !== 1'b0) begin n_err++; $display("FAIL abort_mem_ready: got %0b want 0", u_if.bus_arb_mem_ready_o); end
        n_cmp++; if (u_if.bus_arb_bus_valid_o !== 1'b0) begin n_err++; $display("FAIL abort_bus_valid: got %0b want 0", u_if.bus_arb_bus_valid_o); end
        tick();
        u_if.bus_arb_bus_ready_i = 1'b0;
        #1;
        n_cmp++; if (u_if.bus_arb_owner_o !== 2'b00) begin n_err++; $display("FAIL abort_owner: got %0h want 0", u_if.bus_arb_owner_o); end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        tick();
        u_if.bus_arb_mem_valid_i = 1'b1;
        u_if.bus_arb_mem_addr_i  = 64'h8000_3000;
        tick(); #1;
        n_cmp++; if (u_if.bus_arb_owner_o !== 2'b10) begin n_err++; $display("FAIL rstmid_grant: got %0h want 2", u_if.bus_arb_owner_o); end
        #1;
        u_if.bus_arb_bus_ready_i = 1'b1;
        rst = 1'b1;
        #1;
        n_cmp++; if (u_if.bus_arb_owner_o !== 2'b00) begin n_err++; $display("FAIL rstmid_owner: got %0h want 0", u_if.bus_arb_owner_o); end
        n_cmp++; if (u_if.bus_arb_bus_valid_o !== 1'b0) begin n_err++; $display("FAIL rstmid_bus_valid: got %0b want 0", u_if.bus_arb_bus_valid_o); end
        n_cmp++; if ({u_if.bus_arb_if_ready_o, u_if.bus_arb_mem_ready_o} !== 2'b00) begin n_err++; $display("FAIL rstmid_readys: got %0b%0b want 00", u_if.bus_arb_if_ready_o, u_if.bus_arb_mem_ready_o); end
        tick();
        rst = 1'b0;
        clear_inputs();
        u_if.bus_arb_if_valid_i = 1'b1;
        u_if.bus_arb_if_addr_i  = 64'h8000_0100;
        tick(); #1;
        n_cmp++; if (u_if.bus_arb_owner_o !== 2'b01 || u_if.bus_arb_bus_addr_o !== 64'h8000_0100) begin n_err++; $display("FAIL rstmid_fetch_grant: got owner %0h addr %h want 1 80000100", u_if.bus_arb_owner_o, u_if.bus_arb_bus_addr_o); end
        u_if.bus_arb_bus_ready_i = 1'b1;
        #1;
        n_cmp++; if (u_if.bus_arb_if_ready_o !== 1'b1) begin n_err++; $display("FAIL rstmid_fetch_done: got %0b want 1", u_if.bus_arb_if_ready_o); end
        tick();
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        tick();
        u_if.bus_arb_if_valid_i      = 1'b1;
        u_if.bus_arb_if_addr_i       = 64'h8000_0200;
        u_if.bus_arb_bus_ready_i     = 1'b1;
        u_if.bus_arb_bus_resp_i      = 2'b10;
        u_if.bus_arb_bus_data_read_i = 64'h0000_cafe_f00d_0001;
        for (int i = 0; i < 6; i++) begin
            logic exp_rdy;
            exp_rdy = (i % 2 == 0);
            tick(); #1;
            n_cmp++; if (u_if.bus_arb_owner_o !== (exp_rdy ? 2'b01 : 2'b00)) begin n_err++; $display("FAIL b2b_owner[%0d]: got %0h want %0h", i, u_if.bus_arb_owner_o, exp_rdy ? 2'b01 : 2'b00); end
            n_cmp++; if (u_if.bus_arb_if_ready_o !== exp_rdy) begin n_err++; $display("FAIL b2b_ready[%0d]: got %0b want %0b", i, u_if.bus_arb_if_ready_o, exp_rdy); end
            n_cmp++; if (u_if.bus_arb_if_resp_o !== (exp_rdy ? 2'b10 : 2'b00)) begin n_err++; $display("FAIL b2b_resp[%0d]: got %0h want %0h", i, u_if.bus_arb_if_resp_o, exp_rdy ? 2'b10 : 2'b00); end
            n_cmp++; if (u_if.bus_arb_mem_ready_o !== 1'b0 || u_if.bus_arb_mem_resp_o !== 2'b00) begin n_err++; $display("FAIL b2b_mem_quiet[%0d]: got ready %0b resp %0h want 0 0", i, u_if.bus_arb_mem_ready_o, u_if.bus_arb_mem_resp_o); end
        end
        tick();
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_fetch_read();
        test_both_valid();
        test_starvation();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master, one-slave arbiter. Shares the single core memory bus between the instruction-fetch port (read-only) and the mem-stage data port (read/write, output side of the clint distributor).
- Sits between the fetch unit / mem-stage memory path and the top-level bus bridge.
- Uses the same valid/ready/req/size/resp handshake on all three sides.
- Fixed priority to the data side, with a starvation guard for fetch.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width.
- STARVE_LIMIT, 4, number of consecutive data-side grants allowed while fetch is waiting; the next grant then goes to fetch.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- bus_arb_if_valid_i  in  1  fetch request valid
- bus_arb_if_ready_o  out  1  fetch transfer complete
- bus_arb_if_addr_i  in  ADDR_W  fetch address
- bus_arb_if_size_i  in  2  fetch size
- bus_arb_if_data_read_o  out  DATA_W  fetch read data
- bus_arb_if_resp_o  out  2  fetch response
- bus_arb_mem_valid_i  in  1  data request valid
- bus_arb_mem_ready_o  out  1  data transfer complete
- bus_arb_mem_req_i  in  1  1 = write, 0 = read
- bus_arb_mem_addr_i  in  ADDR_W  data address
- bus_arb_mem_size_i  in  2  data size
- bus_arb_mem_data_write_i  in  DATA_W  write data
- bus_arb_mem_data_read_o  out  DATA_W  read data
- bus_arb_mem_resp_o  out  2  data response
- bus_arb_bus_valid_o  out  1  bus request valid
- bus_arb_bus_ready_i  in  1  bus transfer complete
- bus_arb_bus_req_o  out  1  1 = write
- bus_arb_bus_addr_o  out  ADDR_W  bus address
- bus_arb_bus_size_o  out  2  bus size
- bus_arb_bus_data_write_o  out  DATA_W  bus write data
- bus_arb_bus_data_read_i  in  DATA_W  bus read data
- bus_arb_bus_resp_i  in  2  bus response
- bus_arb_owner_o  out  2  registered grant: 00 none, 01 fetch, 10 data

Behaviour:
- State machine: IDLE, GNT_IF, GNT_MEM, with a registered state. Reset is asynchronous on rst high and forces:
  - state = IDLE
  - starvation counter = 0
  - all outputs 0
- IDLE:
  - Both bus_arb_if_valid_i and bus_arb_mem_valid_i sampled at the clock edge.
  - Only data valid -> GNT_MEM.
  - Only fetch valid -> GNT_IF.
  - Both valid -> GNT_MEM, unless counter == STARVE_LIMIT, in which case -> GNT_IF.
  - Neither valid -> stay in IDLE.
- Bus outputs in a GNT_* state are combinational from the granted master.
  - Fetch grant drives req_o = 0 and data_write_o = 0.
  - In IDLE, bus_valid_o = 0 and all bus outputs are 0.
- Latency: one arbitration cycle. A request asserted in cycle N, with the arbiter in IDLE, gives bus_valid_o = 1 in cycle N+1.
- Completion: in a GNT_* state with bus_valid_o & bus_arb_bus_ready_i:
  - the granted master's ready_o = 1 in the same cycle;
  - its data_read_o and resp_o pass through combinationally;
  - next state = IDLE.
- The non-granted master always sees ready_o = 0, data_read_o = 0 and resp_o = 0.
- Back-to-back transfers always pass through IDLE, giving one bubble between transfers.
- Starvation counter (width clog2(STARVE_LIMIT+1)), updated at each grant decision:
  - +1 (saturating) on a data grant taken while fetch valid is high;
  - cleared on any fetch grant;
  - cleared on a data grant while fetch valid is low.
- Abort (pipeline flush): if the granted master drops its valid before ready:
  - bus_valid_o follows its valid combinationally and goes 0;
  - next state = IDLE;
  - the counter is unchanged;
  - a bus ready arriving in that same cycle is ignored, so no master ready is issued.
- Ready with valid: bus_arb_bus_ready_i is ignored whenever bus_valid_o = 0.
- Master input stability: masters hold addr/size/req/data stable while valid is high. The arbiter does not latch them.
- Reset mid-transfer: the arbiter returns to IDLE immediately. The bus slave must tolerate the abandoned request.
- bus_arb_owner_o mirrors state: IDLE = 00, GNT_IF = 01, GNT_MEM = 10.

Test Plan:
- Reset, then a fetch read of 0x80000000 with slave ready after 2 cycles:
  - bus_valid_o rises 1 cycle after if_valid, with addr 0x80000000 and req_o = 0;
  - if_ready_o pulses 1 cycle together with if_data_read_o = slave data;
  - owner goes 01 -> 00.
- Both fetch and data valid in IDLE, data write 0xdeadbeef to 0x80001000 size 2'b11:
  - data granted first with bus_req_o = 1 and data_write_o = 0xdeadbeef;
  - one IDLE bubble, then fetch granted.
- Data valid continuously and fetch waiting, STARVE_LIMIT = 4:
  - the grant sequence is data×4, then fetch, then data;
  - the counter clears after the fetch grant.
- Granted data master drops valid in the 2nd wait cycle while the slave raises ready in that cycle:
  - mem_ready_o stays 0 and bus_valid_o goes 0 that cycle;
  - next state is IDLE and owner = 00.
- rst pulsed while in GNT_MEM:
  - owner = 00, bus_valid_o = 0 and all ready_o = 0 asynchronously;
  - a new fetch request after reset is granted normally.
- Slave ready held permanently high and only fetch requesting:
  - transfers complete every 2 cycles (grant, IDLE);
  - resp_i = 2'b10 passes through to if_resp_o.
